traffic_ctrl_param: RTL and testbench

- Parametrised successor to the two-road highway/farm-road traffic controller.
- Long, short and clearance timers are internal and set by parameters, so no external timer block is needed.
- Adds an optional all-red clearance phase and fully encoded light outputs.
- Sits at the top of the intersection subsystem and drives lamp drivers directly.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/tl_timer.sv | 19 +
 rtl/traffic_ctrl_param.sv | 123 ++++++++++++
 tb/tb_traffic_ctrl_param.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the parametrised highway/farm-road traffic controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED = 2'b00,
        YEL = 2'b01,
        GRN = 2'b10
    } light_e;

    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        HR = 3'd2,
        FG = 3'd3,
        FY = 3'd4,
        FR = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int d);
        int m;
        m = (a > b) ? a : b;
        return (m > d) ? m : d;
    endfunction

endpackage

// File: rtl/tl_timer.sv
// Saturating phase timer: cleared on state entry, counts up and holds at all-ones.
module tl_timer #(
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [TW-1:0] tmr
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            tmr <= '0;
        end else if (tmr != '1) begin
            tmr <= tmr + TW'(1);
        end
    end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Highway/farm-road traffic controller with internal timers and optional all-red clearance.
// Define TRAFFIC_PED_REQ_EN to add the pedestrian request input and walk output.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int LONG_CYC   = 8,
    parameter int SHORT_CYC  = 3,
    parameter int ALLRED_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [1:0] hw_light,
    output logic [1:0] fm_light,
    output logic       st,
    output logic [2:0] state_o
);

    localparam int unsigned TW = $clog2(max3(LONG_CYC, SHORT_CYC, ALLRED_CYC) + 1);

    localparam int unsigned LongThr   = (LONG_CYC > 1)   ? LONG_CYC - 1   : 0;
    localparam int unsigned ShortThr  = (SHORT_CYC > 1)  ? SHORT_CYC - 1  : 0;
    localparam int unsigned AllredThr = (ALLRED_CYC > 1) ? ALLRED_CYC - 1 : 0;

    state_e        state;
    state_e        nxt;
    logic [TW-1:0] tmr;
    logic          tl;
    logic          ts;
    logic          ta;
    logic          clr;
    logic          req;
    light_e        hw_l;
    light_e        fm_l;

    tl_timer #(
        .TW(TW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tmr  (tmr)
    );

    assign tl  = 32'(tmr) >= LongThr;
    assign ts  = 32'(tmr) >= ShortThr;
    assign ta  = 32'(tmr) >= AllredThr;
    assign clr = (nxt != state);

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_flag;

    // Sticky request, consumed when the farm road (and crossing) goes green.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_flag <= 1'b0;
        end else if (nxt == FG && state != FG) begin
            ped_flag <= 1'b0;
        end else if (ped_req) begin
            ped_flag <= 1'b1;
        end
    end

    assign req      = c | ped_flag;
    assign ped_walk = (state == FG) || (state == FR);
`else
    assign req = c;
`endif

    always_comb begin
        nxt = state;
        case (state)
            HG: if (req && tl) nxt = HY;
            HY: begin
                if (ts) begin
                    if (ALLRED_CYC == 0) nxt = FG;
                    else                 nxt = HR;
                end
            end
            HR: if (ta) nxt = FG;
            FG: if (!c || tl) nxt = FY;
            FY: begin
                if (ts) begin
                    if (ALLRED_CYC == 0) nxt = HG;
                    else                 nxt = FR;
                end
            end
            FR: if (ta) nxt = HG;
            default: nxt = HG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HG;
            st    <= 1'b0;
        end else begin
            state <= nxt;
            st    <= clr;
        end
    end

    always_comb begin
        hw_l = RED;
        fm_l = RED;
        case (state)
            HG:      hw_l = GRN;
            HY:      hw_l = YEL;
            FG:      fm_l = GRN;
            FY:      fm_l = YEL;
            default: ;
        endcase
    end

    assign hw_light = hw_l;
    assign fm_light = fm_l;
    assign state_o  = state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: default build plus an ALLRED_CYC=0 instance.
module tb_traffic_ctrl_param;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       c;
    logic [1:0] hw_light, fm_light, hw0, fm0;
    logic       st, st0;
    logic [2:0] state_o, state0;
`ifdef TRAFFIC_PED_REQ_EN
    logic       ped_req, ped_walk, walk0;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    traffic_ctrl_param #(
        .LONG_CYC(8), .SHORT_CYC(3), .ALLRED_CYC(2)
    ) dut (
        .clk(clk), .reset(reset), .c(c),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(ped_req), .ped_walk(ped_walk),
`endif
        .hw_light(hw_light), .fm_light(fm_light), .st(st), .state_o(state_o)
    );

    traffic_ctrl_param #(
        .LONG_CYC(8), .SHORT_CYC(3), .ALLRED_CYC(0)
    ) dut0 (
        .clk(clk), .reset(reset), .c(c),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_req(ped_req), .ped_walk(walk0),
`endif
        .hw_light(hw0), .fm_light(fm0), .st(st0), .state_o(state0)
    );

    // Reference lamp decode and c=1 dwell times.
    function automatic logic [1:0] exp_hw(input logic [2:0] s);
        case (s)
            HG:      return 2'b10;
            HY:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] exp_fm(input logic [2:0] s);
        case (s)
            FG:      return 2'b10;
            FY:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int full_dwell(input logic [2:0] s);
        case (s)
            HG, FG:  return 8;
            HY, FY:  return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] next_s(input bit alt, input logic [2:0] s);
        case (s)
            HG:      return HY;
            HY:      return alt ? FG : HR;
            HR:      return FG;
            FG:      return FY;
            FY:      return alt ? HG : FR;
            default: return HG;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic cv);
        reset = 1'b1;
        c     = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        ped_req = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        c     = cv;
    endtask

    task automatic sample(input bit alt, output logic [2:0] s, output logic [1:0] h,
                          output logic [1:0] f, output logic t, output logic w);
        s = alt ? state0 : state_o;
        h = alt ? hw0 : hw_light;
        f = alt ? fm0 : fm_light;
        t = alt ? st0 : st;
        w = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        w = alt ? walk0 : ped_walk;
`endif
    endtask

    // Measures how long the current state lasts (bounded at 100) and what was seen meanwhile.
    task automatic dwell(input bit alt, output int n, output logic [1:0] hf, output logic [1:0] ff,
                         output logic stf, output bit stl, output bit both, output bit allred,
                         output bit wall, output bit wany);
        logic [2:0] s0, s;
        logic [1:0] h, f;
        logic       t, w;
        sample(alt, s0, hf, ff, stf, w);
        n = 0; stl = 0; both = 0; allred = 0; wall = 1; wany = 0;
        while (n < 100) begin
            sample(alt, s, h, f, t, w);
            if (s !== s0) break;
            if (h != 2'b00 && f != 2'b00) both = 1;
            if (h == 2'b00 && f == 2'b00) allred = 1;
            if (n > 0 && t) stl = 1;
            if (!w) wall = 0;
            if (w) wany = 1;
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        c     = 1'b0;
        step();
        step();
        compared++;
        if ({state_o, hw_light, fm_light, st} !== {HG, 2'b10, 2'b00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got %h want %h", {state_o, hw_light, fm_light, st},
                     {HG, 2'b10, 2'b00, 1'b0});
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            compared++;
            if ({state_o, hw_light, fm_light, st} !== {HG, 2'b10, 2'b00, 1'b0}) begin
                mismatched++;
                $display("FAIL idle_hold[%0d]: got %h want %h", i,
                         {state_o, hw_light, fm_light, st}, {HG, 2'b10, 2'b00, 1'b0});
            end
            step();
        end
        // Timer has long since saturated, so a car now leaves HG on the very next edge.
        c = 1'b1;
        step();
        compared++;
        if ({state_o, st} !== {HY, 1'b1}) begin
            mismatched++;
            $display("FAIL saturated_timer: got %h want %h", {state_o, st}, {HY, 1'b1});
        end
    endtask

    task automatic test_full_cycle();
        int n; logic [1:0] hf, ff; logic stf; bit stl, both, ar, wa, wy;
        logic [2:0] s, e;
        logic [18:0] got, want;
        do_reset(1'b1);
        e = HG;
        for (int i = 0; i < 6; i++) begin
            s = state_o;
            dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
            got  = {s, 8'(n), stf, stl, both, ar, hf, ff};
            want = {e, 8'(full_dwell(e)), (i != 0), 1'b0, 1'b0, (e == HR || e == FR),
                    exp_hw(e), exp_fm(e)};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL full_cycle[%0d]: got %h want %h (state,dwell,st,st_later,both_lit,all_red,hw,fm)",
                         i, got, want);
            end
            e = next_s(1'b0, e);
        end
        compared++;
        if ({state_o, st} !== {HG, 1'b1}) begin
            mismatched++;
            $display("FAIL full_cycle_wrap: got %h want %h", {state_o, st}, {HG, 1'b1});
        end
    endtask

    task automatic test_early_release();
        int n; logic [1:0] hf, ff; logic stf; bit stl, both, ar, wa, wy;
        logic [2:0] s, e;
        do_reset(1'b1);
        e = HG;
        for (int i = 0; i < 3; i++) begin
            s = state_o;
            dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
            e = next_s(1'b0, e);
        end
        compared++;
        if (state_o !== FG) begin
            mismatched++;
            $display("FAIL early_fg_entry: got %0d want %0d", state_o, FG);
        end
        step();
        step();
        c = 1'b0;
        dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
        compared++;
        if (n + 2 !== 3) begin
            mismatched++;
            $display("FAIL early_fg_dwell: got %0d want 3", n + 2);
        end
        e = FY;
        for (int i = 0; i < 2; i++) begin
            s = state_o;
            dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
            compared++;
            if ({s, 8'(n)} !== {e, 8'(full_dwell(e))}) begin
                mismatched++;
                $display("FAIL early_tail[%0d]: got %h want %h", i, {s, 8'(n)},
                         {e, 8'(full_dwell(e))});
            end
            e = next_s(1'b0, e);
        end
        compared++;
        if ({state_o, st} !== {HG, 1'b1}) begin
            mismatched++;
            $display("FAIL early_return: got %h want %h", {state_o, st}, {HG, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        int n; logic [1:0] hf, ff; logic stf; bit stl, both, ar, wa, wy;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
        compared++;
        if (state_o !== FY) begin
            mismatched++;
            $display("FAIL mid_reach_fy: got %0d want %0d", state_o, FY);
        end
        step();
        reset = 1'b1;
        step();
        compared++;
        if ({state_o, hw_light, fm_light, st} !== {HG, 2'b10, 2'b00, 1'b0}) begin
            mismatched++;
            $display("FAIL mid_reset: got %h want %h", {state_o, hw_light, fm_light, st},
                     {HG, 2'b10, 2'b00, 1'b0});
        end
        reset = 1'b0;
        c     = 1'b1;
        dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
        compared++;
        if ({8'(n), state_o} !== {8'd8, HY}) begin
            mismatched++;
            $display("FAIL mid_hg_dwell: got %h want %h", {8'(n), state_o}, {8'd8, HY});
        end
    endtask

    task automatic test_no_allred();
        int n; logic [1:0] hf, ff; logic stf; bit stl, both, ar, wa, wy;
        logic [2:0] s, e;
        logic [19:0] got, want;
        do_reset(1'b1);
        e = HG;
        for (int i = 0; i < 4; i++) begin
            s = state0;
            dwell(1'b1, n, hf, ff, stf, stl, both, ar, wa, wy);
            got  = {s, 8'(n), stf, stl, both, ar, wy, hf, ff};
            want = {e, 8'(full_dwell(e)), (i != 0), 1'b0, 1'b0, 1'b0, 1'b0, exp_hw(e), exp_fm(e)};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL no_allred[%0d]: got %h want %h (state,dwell,st,st_later,both_lit,all_red,walk,hw,fm)",
                         i, got, want);
            end
            e = next_s(1'b1, e);
        end
        compared++;
        if ({state0, st0} !== {HG, 1'b1}) begin
            mismatched++;
            $display("FAIL no_allred_wrap: got %h want %h", {state0, st0}, {HG, 1'b1});
        end
    endtask

`ifdef TRAFFIC_PED_REQ_EN
    task automatic test_ped();
        int n; logic [1:0] hf, ff; logic stf; bit stl, both, ar, wa, wy;
        logic [2:0] s, e;
        int exp_n;
        bit walk;
        do_reset(1'b0);
        step();
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
        compared++;
        if ({8'(n + 3), wy, state_o} !== {8'd8, 1'b0, HY}) begin
            mismatched++;
            $display("FAIL ped_hg: got %h want %h", {8'(n + 3), wy, state_o}, {8'd8, 1'b0, HY});
        end
        e = HY;
        for (int i = 0; i < 5; i++) begin
            s = state_o;
            dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
            exp_n = (e == FG) ? 1 : full_dwell(e);
            walk  = (e == FG || e == FR);
            compared++;
            if ({s, 8'(n), wa, wy} !== {e, 8'(exp_n), walk, walk}) begin
                mismatched++;
                $display("FAIL ped_seq[%0d]: got %h want %h (state,dwell,walk_all,walk_any)",
                         i, {s, 8'(n), wa, wy}, {e, 8'(exp_n), walk, walk});
            end
            e = next_s(1'b0, e);
        end
        dwell(1'b0, n, hf, ff, stf, stl, both, ar, wa, wy);
        compared++;
        if ({8'(n), wy, state_o} !== {8'd100, 1'b0, HG}) begin
            mismatched++;
            $display("FAIL ped_flag_cleared: got %h want %h", {8'(n), wy, state_o},
                     {8'd100, 1'b0, HG});
        end
    endtask
`endif

    initial begin
`ifdef TRAFFIC_PED_REQ_EN
        ped_req = 1'b0;
`endif
        test_reset();
        test_full_cycle();
        test_early_release();
        test_reset_mid();
        test_no_allred();
`ifdef TRAFFIC_PED_REQ_EN
        test_ped();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
